hynoc_port_allocator: RTL and testbench
=======================================

// Module: hynoc_port_allocator
// PURPOSE
//  Wormhole output-port allocator for the hynoc switch. It shares one output
//  link between WIDTH input ports using round-robin arbitration. Grant is held
//  from head flit to EOP flit, so packets never interleave. It muxes the
//  owner's flit stream onto the output with a valid/ready handshake.
//  One instance sits in front of each switch output port.
// PARAMETERS
//  WIDTH       4   number of requesting input ports (>=2)
//  LOG2_WIDTH  2   clog2(WIDTH), width of owner index
//  FLIT_WIDTH  32  flit payload width in bits
// PORTS
//  clk        in   1                 clock, all state on rising edge
//  arst       in   1                 asynchronous reset, active high
//  in_valid   in   WIDTH             per-port flit valid
//  in_eop     in   WIDTH             per-port end-of-packet marker, qualified by in_valid
//  in_data    in   WIDTH*FLIT_WIDTH  per-port flit, port i at [i*FLIT_WIDTH +: FLIT_WIDTH]
//  in_ready   out  WIDTH             per-port flit accepted
//  out_valid  out  1                 output flit valid
//  out_eop    out  1                 output end-of-packet
//  out_data   out  FLIT_WIDTH        output flit
//  out_ready  in   1                 downstream accepts flit
//  grant      out  WIDTH             one-hot current owner, 0 when idle
//  owner      out  LOG2_WIDTH        index of current or last owner
//  busy       out  1                 1 while a packet is locked
// BEHAVIOUR
//  - Reset (arst=1, async): state=IDLE, grant=0, owner=WIDTH-1 (port 0 has
//    first priority), busy=0. in_ready=0 and out_valid=0 combinationally.
//  - FSM, 2 states:
//    IDLE: if in_valid != 0, pick the first i with in_valid[i]=1, searching
//      owner+1, owner+2, ... mod WIDTH. Register grant=onehot(i), owner=i,
//      busy=1, go LOCKED. Otherwise hold state.
//      Arbitration latency is 1 cycle. No flit transfers in IDLE.
//    LOCKED: out_valid=in_valid[owner], out_eop=in_eop[owner],
//      out_data=in_data[owner], in_ready[owner]=out_ready, all other in_ready=0.
//      A transfer is in_valid[owner] & out_ready. If the transfer has in_eop=1,
//      go IDLE, grant=0, busy=0, and owner is kept as the round-robin pointer.
//  - Outside LOCKED: out_valid=0, out_eop=0, and out_data is 0 (no X leakage).
//  - Owner drops in_valid mid-packet: stay LOCKED, out_valid=0, and the other
//    ports keep waiting. There is no timeout.
//  - Single-flit packet (head has eop): one LOCKED cycle, if out_ready=1.
//  - Back-to-back packets: one IDLE bubble cycle between the EOP and the next
//    head. The same port regains the grant only if no other port requests.
//  - out_ready=0 while LOCKED: hold all state. The owner sees in_ready=0.
//  - Requests from non-owners during LOCKED are ignored and not latched.
//    Arbitration uses only in_valid sampled in IDLE.
//  - Pointer wrap: owner=WIDTH-1 searches from 0.
//  - arst mid-packet: return to IDLE immediately. The partial packet is
//    abandoned; upstream and downstream handle recovery.
//  - Invariants: grant is one-hot or zero. grant!=0 iff busy.
//    At most one in_ready is high.
// TESTING
//  1 reset: hold arst 3 cycles with random inputs -> grant=0, owner=3, busy=0,
//    in_ready=0, out_valid=0.
//  2 single requester: port 2 sends 4 flits 0xA0..0xA3 (eop on last) with
//    out_ready=1 -> grant=4'b0100 1 cycle after valid, 4 output flits in
//    order, then grant=0.
//  3 fairness: all 4 ports hold in_valid with 2-flit packets -> grant order
//    0,1,2,3,0 with one bubble between packets, and no interleaving on out_data.
//  4 backpressure: port 1 locked, out_ready toggles 1,0,0,1 -> flits advance
//    only when out_ready=1, and in_ready[1] mirrors out_ready.
//  5 stall plus competitor: port 0 locked drops valid 5 cycles while port 3
//    requests -> grant stays 4'b0001, and port 3 is granted after port 0's EOP.
//  6 async reset mid-packet: assert arst between clk edges during flit 2 of 4
//    -> grant=0 and out_valid=0 before the next edge. After release, port 0
//    wins when all ports request.

Source files
------------

// File: rtl/hynoc_port_allocator.sv
// Wormhole output-port allocator: round-robin arbitration among WIDTH input
// ports, grant locked from head flit to EOP flit, owner's flit stream muxed
// onto the single output link with a valid/ready handshake.
module hynoc_port_allocator #(
    parameter int WIDTH      = 4,
    parameter int LOG2_WIDTH = 2,
    parameter int FLIT_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        arst,
    input  logic [WIDTH-1:0]            in_valid,
    input  logic [WIDTH-1:0]            in_eop,
    input  logic [WIDTH*FLIT_WIDTH-1:0] in_data,
    output logic [WIDTH-1:0]            in_ready,
    output logic                        out_valid,
    output logic                        out_eop,
    output logic [FLIT_WIDTH-1:0]       out_data,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            grant,
    output logic [LOG2_WIDTH-1:0]       owner,
    output logic                        busy
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    localparam int unsigned NPORTS = WIDTH;

    state_t                  state;
    state_t                  state_next;
    logic [WIDTH-1:0]        grant_next;
    logic [LOG2_WIDTH-1:0]   owner_next;

    logic                    pick_found;
    logic [LOG2_WIDTH-1:0]   pick_idx;
    logic [LOG2_WIDTH-1:0]   cand;
    int unsigned             scan_idx;

    logic                    sel_valid;
    logic                    sel_eop;
    logic [FLIT_WIDTH-1:0]   sel_data;
    logic [WIDTH-1:0]        owner_hot;

    assign busy = (state == LOCKED);

    // Round-robin search: first requester after the current pointer, wrapping
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = owner;
        cand       = owner;
        scan_idx   = 0;
        for (int unsigned i = 1; i <= NPORTS; i++) begin
            scan_idx = (32'(owner) + i) % NPORTS;
            cand     = LOG2_WIDTH'(scan_idx);
            if (!pick_found && in_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Select the owner's flit stream and decode the owner as a one-hot mask
    always_comb begin
        sel_valid = 1'b0;
        sel_eop   = 1'b0;
        sel_data  = '0;
        owner_hot = '0;
        for (int unsigned i = 0; i < NPORTS; i++) begin
            if (owner == LOG2_WIDTH'(i)) begin
                sel_valid    = in_valid[i];
                sel_eop      = in_eop[i];
                sel_data     = in_data[i*FLIT_WIDTH +: FLIT_WIDTH];
                owner_hot[i] = 1'b1;
            end
        end
    end

    // Next-state and output logic; nothing reaches the output outside LOCKED
    always_comb begin
        state_next = state;
        grant_next = grant;
        owner_next = owner;
        in_ready   = '0;
        out_valid  = 1'b0;
        out_eop    = 1'b0;
        out_data   = '0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_next           = LOCKED;
                    grant_next           = '0;
                    grant_next[pick_idx] = 1'b1;
                    owner_next           = pick_idx;
                end
            end
            LOCKED: begin
                out_valid = sel_valid;
                out_eop   = sel_eop;
                out_data  = sel_data;
                in_ready  = owner_hot & {WIDTH{out_ready}};
                if (sel_valid && out_ready && sel_eop) begin
                    state_next = IDLE;
                    grant_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    // State register; reset leaves the pointer at WIDTH-1 so port 0 wins first
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state <= IDLE;
            grant <= '0;
            owner <= LOG2_WIDTH'(WIDTH - 1);
        end else begin
            state <= state_next;
            grant <= grant_next;
            owner <= owner_next;
        end
    end

endmodule

// File: tb/tb_hynoc_port_allocator.sv
// Directed, table-driven bench for hynoc_port_allocator (WIDTH=4, 32-bit flits).
// Port p presents flit {16'h0, 8'(p), flit_byte}, so out_data identifies the source.
module tb_hynoc_port_allocator;

    logic         clk;
    logic         arst;
    logic [3:0]   in_valid;
    logic [3:0]   in_eop;
    logic [127:0] in_data;
    logic [3:0]   in_ready;
    logic         out_valid;
    logic         out_eop;
    logic [31:0]  out_data;
    logic         out_ready;
    logic [3:0]   grant;
    logic [1:0]   owner;
    logic         busy;

    int errors;
    int checks;

    hynoc_port_allocator #(
        .WIDTH(4),
        .LOG2_WIDTH(2),
        .FLIT_WIDTH(32)
    ) dut (
        .clk(clk),
        .arst(arst),
        .in_valid(in_valid),
        .in_eop(in_eop),
        .in_data(in_data),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_eop(out_eop),
        .out_data(out_data),
        .out_ready(out_ready),
        .grant(grant),
        .owner(owner),
        .busy(busy)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  iv;
        logic [3:0]  ie;
        logic        ordy;
        logic [7:0]  flit;
        logic [3:0]  g;
        logic [1:0]  o;
        logic        b;
        logic [3:0]  ir;
        logic        ov;
        logic        oe;
        logic [31:0] od;
    } vec_t;

    vec_t tab[$];

    function automatic vec_t mk(input logic [3:0] iv, input logic [3:0] ie,
                                input logic ordy, input logic [7:0] flit,
                                input logic [3:0] g, input logic [1:0] o,
                                input logic b, input logic [3:0] ir,
                                input logic ov, input logic oe,
                                input logic [31:0] od);
        vec_t v;
        v.iv = iv; v.ie = ie; v.ordy = ordy; v.flit = flit;
        v.g = g; v.o = o; v.b = b; v.ir = ir; v.ov = ov; v.oe = oe; v.od = od;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp_v);
        end
    endtask

    task automatic drive(input logic [3:0] iv, input logic [3:0] ie,
                         input logic ordy, input logic [7:0] flit);
        in_valid  = iv;
        in_eop    = ie;
        out_ready = ordy;
        for (int p = 0; p < 4; p++)
            in_data[p*32 +: 32] = {16'h0, 8'(p), flit};
    endtask

    task automatic check_all(input string tag, input vec_t v);
        chk({tag, " grant"},     32'(grant),     32'(v.g));
        chk({tag, " owner"},     32'(owner),     32'(v.o));
        chk({tag, " busy"},      32'(busy),      32'(v.b));
        chk({tag, " in_ready"},  32'(in_ready),  32'(v.ir));
        chk({tag, " out_valid"}, 32'(out_valid), 32'(v.ov));
        chk({tag, " out_eop"},   32'(out_eop),   32'(v.oe));
        chk({tag, " out_data"},  out_data,       v.od);
    endtask

    // Drive on the falling edge, sample 1 ns later, state advances on the next rising edge
    task automatic run_vec(input string tag, input vec_t v);
        @(negedge clk);
        drive(v.iv, v.ie, v.ordy, v.flit);
        #1;
        check_all(tag, v);
    endtask

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        errors = 0;
        checks = 0;
        arst = 1'b1;
        drive(4'b0, 4'b0, 1'b0, 8'h00);

        // Reset held 3 cycles with random inputs
        rv = mk(4'b0, 4'b0, 1'b0, 8'h0, 4'b0000, 2'd3, 1'b0, 4'b0000, 1'b0, 1'b0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(4'($urandom), 4'($urandom), 1'($urandom), 8'($urandom));
            #1;
            check_all($sformatf("reset%0d", c), rv);
        end
        @(negedge clk);
        arst = 1'b0;
        drive(4'b0, 4'b0, 1'b1, 8'h00);

        // Fairness: all ports request 2-flit packets, order 0,1,2,3,0
        tab.push_back(mk(4'b1111, 4'b0000, 1, 8'h10, 4'b0000, 2'd3, 0, 4'b0000, 0, 0, 32'h0));
        tab.push_back(mk(4'b1111, 4'b0000, 1, 8'h10, 4'b0001, 2'd0, 1, 4'b0001, 1, 0, 32'h010));
        tab.push_back(mk(4'b1111, 4'b0001, 1, 8'h11, 4'b0001, 2'd0, 1, 4'b0001, 1, 1, 32'h011));
        tab.push_back(mk(4'b1111, 4'b0000, 1, 8'h10, 4'b0000, 2'd0, 0, 4'b0000, 0, 0, 32'h0));
        tab.push_back(mk(4'b1111, 4'b0000, 1, 8'h10, 4'b0010, 2'd1, 1, 4'b0010, 1, 0, 32'h110));
        tab.push_back(mk(4'b1111, 4'b0010, 1, 8'h11, 4'b0010, 2'd1, 1, 4'b0010, 1, 1, 32'h111));
        tab.push_back(mk(4'b1111, 4'b0000, 1, 8'h10, 4'b0000, 2'd1, 0, 4'b0000, 0, 0, 32'h0));
        tab.push_back(mk(4'b1111, 4'b0000, 1, 8'h10, 4'b0100, 2'd2, 1, 4'b0100, 1, 0, 32'h210));
        tab.push_back(mk(4'b1111, 4'b0100, 1, 8'h11, 4'b0100, 2'd2, 1, 4'b0100, 1, 1, 32'h211));
        tab.push_back(mk(4'b1111, 4'b0000, 1, 8'h10, 4'b0000, 2'd2, 0, 4'b0000, 0, 0, 32'h0));
        tab.push_back(mk(4'b1111, 4'b0000, 1, 8'h10, 4'b1000, 2'd3, 1, 4'b1000, 1, 0, 32'h310));
        tab.push_back(mk(4'b1111, 4'b1000, 1, 8'h11, 4'b1000, 2'd3, 1, 4'b1000, 1, 1, 32'h311));
        tab.push_back(mk(4'b1111, 4'b0000, 1, 8'h10, 4'b0000, 2'd3, 0, 4'b0000, 0, 0, 32'h0));
        tab.push_back(mk(4'b1111, 4'b0000, 1, 8'h10, 4'b0001, 2'd0, 1, 4'b0001, 1, 0, 32'h010));
        tab.push_back(mk(4'b1111, 4'b0001, 1, 8'h11, 4'b0001, 2'd0, 1, 4'b0001, 1, 1, 32'h011));
        tab.push_back(mk(4'b0000, 4'b0000, 1, 8'h00, 4'b0000, 2'd0, 0, 4'b0000, 0, 0, 32'h0));
        // Single requester: port 2 sends A0..A3
        tab.push_back(mk(4'b0100, 4'b0000, 1, 8'hA0, 4'b0000, 2'd0, 0, 4'b0000, 0, 0, 32'h0));
        tab.push_back(mk(4'b0100, 4'b0000, 1, 8'hA0, 4'b0100, 2'd2, 1, 4'b0100, 1, 0, 32'h2A0));
        tab.push_back(mk(4'b0100, 4'b0000, 1, 8'hA1, 4'b0100, 2'd2, 1, 4'b0100, 1, 0, 32'h2A1));
        tab.push_back(mk(4'b0100, 4'b0000, 1, 8'hA2, 4'b0100, 2'd2, 1, 4'b0100, 1, 0, 32'h2A2));
        tab.push_back(mk(4'b0100, 4'b0100, 1, 8'hA3, 4'b0100, 2'd2, 1, 4'b0100, 1, 1, 32'h2A3));
        tab.push_back(mk(4'b0000, 4'b0000, 1, 8'h00, 4'b0000, 2'd2, 0, 4'b0000, 0, 0, 32'h0));
        // Backpressure: port 1 locked, out_ready 1,0,0,1; eop held under stall
        tab.push_back(mk(4'b0010, 4'b0000, 1, 8'h50, 4'b0000, 2'd2, 0, 4'b0000, 0, 0, 32'h0));
        tab.push_back(mk(4'b0010, 4'b0000, 1, 8'h50, 4'b0010, 2'd1, 1, 4'b0010, 1, 0, 32'h150));
        tab.push_back(mk(4'b0010, 4'b0010, 0, 8'h51, 4'b0010, 2'd1, 1, 4'b0000, 1, 1, 32'h151));
        tab.push_back(mk(4'b0010, 4'b0010, 0, 8'h51, 4'b0010, 2'd1, 1, 4'b0000, 1, 1, 32'h151));
        tab.push_back(mk(4'b0010, 4'b0010, 1, 8'h51, 4'b0010, 2'd1, 1, 4'b0010, 1, 1, 32'h151));
        tab.push_back(mk(4'b0000, 4'b0000, 1, 8'h00, 4'b0000, 2'd1, 0, 4'b0000, 0, 0, 32'h0));
        // Stall plus competitor: port 0 drops valid 5 cycles, port 3 waits
        tab.push_back(mk(4'b0001, 4'b0000, 1, 8'h60, 4'b0000, 2'd1, 0, 4'b0000, 0, 0, 32'h0));
        tab.push_back(mk(4'b0001, 4'b0000, 1, 8'h60, 4'b0001, 2'd0, 1, 4'b0001, 1, 0, 32'h060));
        for (int k = 0; k < 5; k++)
            tab.push_back(mk(4'b1000, 4'b0000, 1, 8'h61, 4'b0001, 2'd0, 1, 4'b0001, 0, 0, 32'h061));
        tab.push_back(mk(4'b1001, 4'b0001, 1, 8'h61, 4'b0001, 2'd0, 1, 4'b0001, 1, 1, 32'h061));
        tab.push_back(mk(4'b1000, 4'b0000, 1, 8'h70, 4'b0000, 2'd0, 0, 4'b0000, 0, 0, 32'h0));
        // Single-flit packet from port 3
        tab.push_back(mk(4'b1000, 4'b1000, 1, 8'h70, 4'b1000, 2'd3, 1, 4'b1000, 1, 1, 32'h370));
        tab.push_back(mk(4'b0000, 4'b0000, 1, 8'h00, 4'b0000, 2'd3, 0, 4'b0000, 0, 0, 32'h0));

        foreach (tab[i])
            run_vec($sformatf("vec%0d", i), tab[i]);

        // Async reset mid-packet: port 0 locked (pointer wrap 3 -> 0)
        run_vec("ar_idle", mk(4'b0001, 4'b0000, 1, 8'h80, 4'b0000, 2'd3, 0, 4'b0000, 0, 0, 32'h0));
        run_vec("ar_f1",   mk(4'b0001, 4'b0000, 1, 8'h80, 4'b0001, 2'd0, 1, 4'b0001, 1, 0, 32'h080));
        run_vec("ar_f2",   mk(4'b0001, 4'b0000, 1, 8'h81, 4'b0001, 2'd0, 1, 4'b0001, 1, 0, 32'h081));
        #2;
        arst = 1'b1;
        #1;
        check_all("ar_async", mk(4'b0001, 4'b0000, 1, 8'h81, 4'b0000, 2'd3, 0, 4'b0000, 0, 0, 32'h0));
        @(negedge clk);
        arst = 1'b0;
        drive(4'b1111, 4'b0000, 1'b1, 8'h90);
        #1;
        check_all("ar_rel", mk(4'b1111, 4'b0000, 1, 8'h90, 4'b0000, 2'd3, 0, 4'b0000, 0, 0, 32'h0));
        run_vec("ar_win",  mk(4'b1111, 4'b0000, 1, 8'h90, 4'b0001, 2'd0, 1, 4'b0001, 1, 0, 32'h090));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
